// File: rtl/uart8_transmitter_if.sv
// Byte handshake and serial line bundle for the 8N1 UART transmitter.
interface uart8_transmitter_if;
  logic       txEn;
  logic       txStart;
  logic [7:0] txData;
  logic       txReady;
  logic       txBusy;
  logic       txDone;
  logic       txOut;

  modport master (
    output txEn, txStart, txData,
    input  txReady, txBusy, txDone, txOut
  );

  modport slave (
    input  txEn, txStart, txData,
    output txReady, txBusy, txDone, txOut
  );
endinterface

// File: rtl/uart8_transmitter.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// A one-byte holding register lets the next frame follow with no idle gap.
// The line output is registered from the current state, so it trails the
// state register by one clock; a byte accepted at edge N drives the start
// bit from edge N+2.
module uart8_transmitter #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic               clk,
  input  logic               reset,
  uart8_transmitter_if.slave bus
);

  localparam int CPB  = CLOCK_RATE / BAUD_RATE;
  localparam int BC_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CPB - 1);

  if (CPB < 2) begin : g_cpb_check
    $error("uart8_transmitter: CLOCK_RATE / BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state;
  logic [7:0]      r_sh;
  logic [2:0]      r_bi;
  logic [BC_W-1:0] r_bc;
  logic [7:0]      r_hold;
  logic            r_holdFull;
  logic            r_txOut;
  logic            r_txBusy;
  logic            r_txDone;

  logic w_accept;
  logic w_bcEnd;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign bus.txReady = reset & bus.txEn & ~r_holdFull;
  assign w_accept    = bus.txStart & bus.txReady;
  assign w_bcEnd     = (r_bc == BC_LAST);

  assign bus.txOut  = r_txOut;
  assign bus.txBusy = r_txBusy;
  assign bus.txDone = r_txDone;

  // Frame sequencer, holding register and registered line/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_sh       <= 8'h00;
      r_bi       <= 3'd0;
      r_bc       <= '0;
      r_hold     <= 8'h00;
      r_holdFull <= 1'b0;
      r_txOut    <= 1'b1;
      r_txBusy   <= 1'b0;
      r_txDone   <= 1'b0;
    end else begin
      r_txDone <= 1'b0;

      // Line level reflects the state held during the cycle just ended.
      case (r_state)
        START:   r_txOut <= 1'b0;
        DATA:    r_txOut <= r_sh[0];
        default: r_txOut <= 1'b1;
      endcase

      // Accept needs an empty holder, launch needs a full one: never both.
      if (w_accept) begin
        r_hold     <= bus.txData;
        r_holdFull <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_bc <= '0;
          if (r_holdFull && bus.txEn) begin
            r_sh       <= r_hold;
            r_holdFull <= 1'b0;
            r_state    <= START;
            r_txBusy   <= 1'b1;
          end
        end
        START: begin
          if (w_bcEnd) begin
            r_state <= DATA;
            r_bi    <= 3'd0;
            r_bc    <= '0;
          end else begin
            r_bc <= r_bc + 1'b1;
          end
        end
        DATA: begin
          if (w_bcEnd) begin
            r_sh <= {1'b0, r_sh[7:1]};
            r_bc <= '0;
            if (r_bi == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bi <= r_bi + 3'd1;
            end
          end else begin
            r_bc <= r_bc + 1'b1;
          end
        end
        STOP: begin
          if (w_bcEnd) begin
            r_txDone <= 1'b1;
            r_bc     <= '0;
            // Chain straight into the next start bit when a byte is waiting.
            if (r_holdFull && bus.txEn) begin
              r_sh       <= r_hold;
              r_holdFull <= 1'b0;
              r_state    <= START;
            end else begin
              r_state  <= IDLE;
              r_txBusy <= 1'b0;
            end
          end else begin
            r_bc <= r_bc + 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_txBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart8_transmitter.sv
// Bench for uart8_transmitter: one instance at the default 12 MHz / 9600 baud
// and one at CLOCK_RATE=8 / BAUD_RATE=2 (four clocks per bit), both checked
// every cycle against a frame-timeline model plus directed expectations.
module tb_uart8_transmitter;

  localparam int CPB_A = 12000000 / 9600;
  localparam int CPB_B = 8 / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  logic       en  [2];
  logic       st  [2];
  logic [7:0] dat [2];
  logic oRdy [2];
  logic oBusy[2];
  logic oDone[2];
  logic oOut [2];

  uart8_transmitter_if busA ();
  uart8_transmitter_if busB ();

  assign busA.txEn    = en[0];
  assign busA.txStart = st[0];
  assign busA.txData  = dat[0];
  assign busB.txEn    = en[1];
  assign busB.txStart = st[1];
  assign busB.txData  = dat[1];
  assign oRdy[0]  = busA.txReady;
  assign oBusy[0] = busA.txBusy;
  assign oDone[0] = busA.txDone;
  assign oOut[0]  = busA.txOut;
  assign oRdy[1]  = busB.txReady;
  assign oBusy[1] = busB.txBusy;
  assign oDone[1] = busB.txDone;
  assign oOut[1]  = busB.txOut;

  uart8_transmitter u_dutA (
    .clk   (clk),
    .reset (rst_n),
    .bus   (busA.slave)
  );

  uart8_transmitter #(.CLOCK_RATE(8), .BAUD_RATE(2)) u_dutB (
    .clk   (clk),
    .reset (rst_n),
    .bus   (busB.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int cpb_of(input int i);
    return (i == 0) ? CPB_A : CPB_B;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- frame-timeline model ----------------
  // Each transmitter is a holder (full/byte) plus an active frame with an
  // elapsed-cycle count t; the line shows bit t/CPB of {stop, data, start}
  // one clock later.
  bit         mFull[2] = '{1'b0, 1'b0};
  logic [7:0] mHold[2];
  bit         mAct [2] = '{1'b0, 1'b0};
  int         mT   [2] = '{0, 0};
  logic [7:0] mByte[2];
  bit         eOut [2] = '{1'b1, 1'b1};
  bit         eBusy[2] = '{1'b0, 1'b0};
  bit         eDone[2] = '{1'b0, 1'b0};

  task automatic model_step(input int i);
    bit         acc;
    bit         preAct;
    int         preT;
    int         c;
    logic [9:0] fr;
    c      = cpb_of(i);
    acc    = st[i] && en[i] && !mFull[i];
    preAct = mAct[i];
    preT   = mT[i];
    fr     = {1'b1, mByte[i], 1'b0};
    eOut[i]  = preAct ? fr[preT / c] : 1'b1;
    eDone[i] = 1'b0;
    if (preAct) begin
      mT[i]++;
      if (mT[i] == 10 * c) begin
        eDone[i] = 1'b1;
        if (mFull[i] && en[i]) begin
          mByte[i] = mHold[i];
          mFull[i] = 1'b0;
          mT[i]    = 0;
        end else begin
          mAct[i] = 1'b0;
        end
      end
    end else if (mFull[i] && en[i]) begin
      mByte[i] = mHold[i];
      mFull[i] = 1'b0;
      mAct[i]  = 1'b1;
      mT[i]    = 0;
    end
    if (acc) begin
      mHold[i] = dat[i];
      mFull[i] = 1'b1;
    end
    eBusy[i] = mAct[i];
  endtask

  // Advance the model on each edge; reset clears it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mFull[i] = 1'b0;
        mAct[i]  = 1'b0;
        mT[i]    = 0;
        eOut[i]  = 1'b1;
        eBusy[i] = 1'b0;
        eDone[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Compare every output of both instances on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("txOut[%0d]", i),   oOut[i],  eOut[i]);
      chk($sformatf("txBusy[%0d]", i),  oBusy[i], eBusy[i]);
      chk($sformatf("txDone[%0d]", i),  oDone[i], eDone[i]);
      chk($sformatf("txReady[%0d]", i), oRdy[i],  rst_n & en[i] & !mFull[i]);
    end
  end

  // ---------------- monitors for directed checks ----------------
  int   doneQ0[$];
  int   doneQ1[$];
  int   transB[$];
  logic prevB = 1'b1;

  always @(negedge clk) begin
    if (oDone[0] === 1'b1) doneQ0.push_back(cyc);
    if (oDone[1] === 1'b1) doneQ1.push_back(cyc);
    if (oOut[1] !== prevB) transB.push_back(cyc);
    prevB = oOut[1];
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int i, input logic [7:0] b, output int acc);
    int w;
    @(negedge clk);
    st[i]  = 1'b1;
    dat[i] = b;
    w = 0;
    while (oRdy[i] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("accept_wait[%0d]", i), (w < 100), 1);
    @(posedge clk);
    @(negedge clk);
    acc    = cyc;
    st[i]  = 1'b0;
    dat[i] = 8'h00;
  endtask

  task automatic cap(input int i, output logic [7:0] b, output int tf);
    int         w;
    int         c;
    logic [9:0] fr;
    c = cpb_of(i);
    w = 0;
    while (oOut[i] !== 1'b0 && w < 20 * c) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("start_edge_wait[%0d]", i), (w < 20 * c), 1);
    tf = cyc;
    repeat (c / 2) @(negedge clk);
    fr[0] = oOut[i];
    for (int k = 1; k < 10; k++) begin
      repeat (c) @(negedge clk);
      fr[k] = oOut[i];
    end
    chk($sformatf("start_bit[%0d]", i), fr[0], 0);
    chk($sformatf("stop_bit[%0d]", i), fr[9], 1);
    b = fr[8:1];
  endtask

  task automatic wait_idle(input int i);
    int w;
    w = 0;
    while (oBusy[i] !== 1'b0 && w < 30000) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("idle_wait[%0d]", i), (w < 30000), 1);
  endtask

  // ---------------- directed sequence ----------------
  int         acc1, acc2, t1, t2, r0, n0;
  logic [7:0] b1, b2;

  initial begin
    for (int i = 0; i < 2; i++) begin
      en[i]  = 1'b0;
      st[i]  = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_txOut[%0d]", i),   oOut[i],  1);
      chk($sformatf("rst_txBusy[%0d]", i),  oBusy[i], 0);
      chk($sformatf("rst_txDone[%0d]", i),  oDone[i], 0);
      chk($sformatf("rst_txReady[%0d]", i), oRdy[i],  0);
    end
    en[0] = 1'b1;
    en[1] = 1'b1;
    #1 chk("rst_ready_with_en", oRdy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_release", oRdy[0], 1);

    // Single 0x56 frame at 1250 clocks per bit.
    doneQ0.delete();
    send(0, 8'h56, acc1);
    cap(0, b1, t1);
    chk("byte_56", b1, 8'h56);
    chk("latency_56", t1 - acc1, 2);
    wait_idle(0);
    repeat (5) @(negedge clk);
    chk("done_count_56", doneQ0.size(), 1);
    if (doneQ0.size() > 0) chk("done_time_56", doneQ0[0] - acc1, 12501);

    // Back-to-back 0xA5 then 0x3C with no idle cycle between them.
    doneQ0.delete();
    send(0, 8'hA5, acc1);
    send(0, 8'h3C, acc2);
    cap(0, b1, t1);
    cap(0, b2, t2);
    chk("byte_A5", b1, 8'hA5);
    chk("byte_3C", b2, 8'h3C);
    chk("b2b_start_gap", t2 - t1, 12500);
    wait_idle(0);
    repeat (5) @(negedge clk);
    chk("b2b_done_count", doneQ0.size(), 2);
    if (doneQ0.size() == 2) chk("b2b_done_gap", doneQ0[1] - doneQ0[0], 12500);

    // Strobe while the holder is full is dropped (4 clocks per bit from here).
    n0 = doneQ1.size();
    send(1, 8'h33, acc1);
    send(1, 8'h11, acc2);
    fork
      begin
        cap(1, b1, t1);
        cap(1, b2, t2);
      end
      begin
        @(negedge clk);
        st[1]  = 1'b1;
        dat[1] = 8'h22;
        #1 chk("ready_when_full", oRdy[1], 0);
        repeat (3) @(negedge clk);
        st[1]  = 1'b0;
        dat[1] = 8'h00;
      end
    join
    chk("byte_33", b1, 8'h33);
    chk("byte_11", b2, 8'h11);
    chk("held_gap", t2 - t1, 40);
    wait_idle(1);
    repeat (100) @(negedge clk);
    chk("full_no_third_frame", doneQ1.size() - n0, 2);

    // Enable dropped mid data bit 3 with 0x7E held.
    n0 = doneQ1.size();
    send(1, 8'h81, acc1);
    send(1, 8'h7E, acc2);
    fork
      cap(1, b1, t1);
      begin
        repeat (18) @(negedge clk);
        en[1] = 1'b0;
      end
    join
    chk("byte_81", b1, 8'h81);
    wait_idle(1);
    repeat (50) @(negedge clk);
    chk("gated_txOut", oOut[1], 1);
    chk("gated_txBusy", oBusy[1], 0);
    chk("gated_txReady", oRdy[1], 0);
    chk("gated_done_count", doneQ1.size() - n0, 1);
    en[1] = 1'b1;
    r0 = cyc;
    cap(1, b2, t2);
    chk("byte_7E", b2, 8'h7E);
    chk("resume_latency", t2 - r0, 2);
    wait_idle(1);
    repeat (5) @(negedge clk);

    // Asynchronous reset during data bit 4.
    send(1, 8'hC3, acc1);
    repeat (23) @(negedge clk);
    chk("pre_reset_busy", oBusy[1], 1);
    n0 = doneQ1.size();
    #2 rst_n = 1'b0;
    #1;
    chk("async_txOut", oOut[1], 1);
    chk("async_txBusy", oBusy[1], 0);
    chk("async_txReady", oRdy[1], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_midframe_reset", oRdy[1], 1);
    repeat (60) @(negedge clk);
    chk("no_done_after_reset", doneQ1.size() - n0, 0);
    send(1, 8'hFF, acc1);
    cap(1, b1, t1);
    chk("byte_FF", b1, 8'hFF);
    wait_idle(1);
    repeat (5) @(negedge clk);

    // Exact 40-cycle frame of 0x01 with bit edges every 4 clocks.
    doneQ1.delete();
    transB.delete();
    send(1, 8'h01, acc1);
    cap(1, b1, t1);
    chk("byte_01", b1, 8'h01);
    wait_idle(1);
    repeat (10) @(negedge clk);
    chk("edge_count_01", transB.size(), 4);
    if (transB.size() == 4) begin
      chk("edge0_01", transB[0] - acc1, 2);
      chk("edge1_01", transB[1] - acc1, 6);
      chk("edge2_01", transB[2] - acc1, 10);
      chk("edge3_01", transB[3] - acc1, 38);
    end
    chk("done_count_01", doneQ1.size(), 1);
    if (doneQ1.size() == 1) chk("done_time_01", doneQ1[0] - acc1, 41);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
